// File: rtl/diad_boot_pkg.sv
// Shared definitions for the diad boot loader: FSM states, error codes,
// the default frame start byte and the byte offsets of the frame header fields.
package diad_boot_pkg;

  typedef enum logic [2:0] {
    S_MAGIC = 3'd0,
    S_LEN0  = 3'd1,
    S_LEN1  = 3'd2,
    S_DATA  = 3'd3,
    S_CSUM  = 3'd4,
    S_RUN   = 3'd5,
    S_ERR   = 3'd6
  } boot_state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_MAGIC = 2'd1,
    ERR_LEN   = 2'd2,
    ERR_CSUM  = 2'd3
  } err_code_t;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hD1;
  localparam int LEN_W = 16;

  // Header layout; the payload starts right after the two length bytes.
  localparam int OFF_MAGIC   = 0;
  localparam int OFF_LEN_LO  = 1;
  localparam int OFF_LEN_HI  = 2;
  localparam int OFF_PAYLOAD = 3;

endpackage

// File: rtl/diad_boot_wordasm.sv
// Byte-to-word assembler: collects BPW bytes little-endian and presents the
// completed word combinationally alongside word_valid on the final byte.
module boot_wordasm #(
  parameter int BPW = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               valid_i,
  input  logic [7:0]         byte_i,
  output logic [8*BPW-1:0]   word_o,
  output logic               word_valid_o
);

  localparam int DATA_W = 8 * BPW;
  localparam int IDX_W  = (BPW > 1) ? $clog2(BPW) : 1;

  if (BPW == 1) begin : g_single
    assign word_o       = byte_i;
    assign word_valid_o = valid_i;
  end else begin : g_multi
    logic [DATA_W-9:0] shift_q;
    logic [IDX_W-1:0]  idx_q;
    logic              last;

    assign last         = (idx_q == IDX_W'(BPW - 1));
    assign word_o       = {byte_i, shift_q};
    assign word_valid_o = valid_i && last;

    // New bytes enter at the top so the first byte ends up least significant.
    always_ff @(posedge clk) begin
      if (!rst_n || clear_i) begin
        shift_q <= '0;
        idx_q   <= '0;
      end else if (valid_i) begin
        shift_q <= word_o[DATA_W-1:8];
        idx_q   <= last ? '0 : idx_q + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/diad_boot.sv
// Boot loader for the diad core: receives a framed image, writes it to memory
// and releases the core only after the checksum has been verified.
module diad_boot
  import diad_boot_pkg::*;
#(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned BASE   = 0,
  parameter logic [7:0]  MAGIC  = MAGIC_DEFAULT
) (
  input  logic              iw_clk,
  input  logic              iw_rst_n,
  input  logic [7:0]        iw_rx_data,
  input  logic              iw_rx_valid,
  output logic              ow_rx_ready,
  output logic              ow_mem_we,
  output logic [ADDR_W-1:0] ow_mem_addr,
  output logic [DATA_W-1:0] ow_mem_wdata,
  output logic              ow_core_rst,
  output logic              ow_done,
  output logic              ow_err,
  output logic [1:0]        ow_err_code
);

  localparam int BPW   = DATA_W / 8;
  localparam int CNT_W = $clog2(DEPTH + 1);

  boot_state_t       state_q;
  logic [LEN_W-1:0]  len_q;
  logic [CNT_W-1:0]  wordCnt_q;
  logic [7:0]        sum_q;
  logic              rxReady_q;
  logic              memWe_q;
  logic [ADDR_W-1:0] memAddr_q;
  logic [DATA_W-1:0] memWdata_q;
  logic              coreRst_q;
  logic              done_q;
  logic              err_q;
  err_code_t         errCode_q;

  logic              accept;
  logic [LEN_W-1:0]  len_d;
  logic [7:0]        sum_d;
  logic              lastWord;
  logic [DATA_W-1:0] asmWord;
  logic              asmWordValid;

  assign accept   = iw_rx_valid && rxReady_q;
  assign len_d    = {iw_rx_data, len_q[7:0]};
  assign sum_d    = sum_q + iw_rx_data;
  assign lastWord = ((32'(wordCnt_q) + 32'd1) == 32'(len_q));

  boot_wordasm #(
    .BPW (BPW)
  ) u_wordasm (
    .clk          (iw_clk),
    .rst_n        (iw_rst_n),
    .clear_i      (accept && (state_q == S_LEN1)),
    .valid_i      (accept && (state_q == S_DATA)),
    .byte_i       (iw_rx_data),
    .word_o       (asmWord),
    .word_valid_o (asmWordValid)
  );

  // Every output is registered; only accepted bytes advance the frame parser.
  always_ff @(posedge iw_clk) begin
    if (!iw_rst_n) begin
      state_q    <= S_MAGIC;
      len_q      <= '0;
      wordCnt_q  <= '0;
      sum_q      <= '0;
      rxReady_q  <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      coreRst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      errCode_q  <= ERR_NONE;
    end else begin
      memWe_q <= 1'b0;
      if (state_q == S_MAGIC && !err_q && !done_q) begin
        rxReady_q <= 1'b1;
      end
      if (accept) begin
        case (state_q)
          S_MAGIC: begin
            if (iw_rx_data == MAGIC) begin
              state_q <= S_LEN0;
            end else begin
              state_q   <= S_ERR;
              err_q     <= 1'b1;
              errCode_q <= ERR_MAGIC;
              rxReady_q <= 1'b0;
            end
          end
          S_LEN0: begin
            len_q[7:0] <= iw_rx_data;
            state_q    <= S_LEN1;
          end
          S_LEN1: begin
            len_q     <= len_d;
            wordCnt_q <= '0;
            sum_q     <= '0;
            if (32'(len_d) > DEPTH) begin
              state_q   <= S_ERR;
              err_q     <= 1'b1;
              errCode_q <= ERR_LEN;
              rxReady_q <= 1'b0;
            end else if (len_d == '0) begin
              state_q <= S_CSUM;
            end else begin
              state_q <= S_DATA;
            end
          end
          S_DATA: begin
            sum_q <= sum_d;
            if (asmWordValid) begin
              memWe_q    <= 1'b1;
              memAddr_q  <= ADDR_W'(BASE) + ADDR_W'(wordCnt_q);
              memWdata_q <= asmWord;
              wordCnt_q  <= wordCnt_q + CNT_W'(1);
              if (lastWord) begin
                state_q <= S_CSUM;
              end
            end
          end
          S_CSUM: begin
            rxReady_q <= 1'b0;
            if (iw_rx_data == sum_q) begin
              state_q   <= S_RUN;
              coreRst_q <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              state_q   <= S_ERR;
              err_q     <= 1'b1;
              errCode_q <= ERR_CSUM;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign ow_rx_ready  = rxReady_q;
  assign ow_mem_we    = memWe_q;
  assign ow_mem_addr  = memAddr_q;
  assign ow_mem_wdata = memWdata_q;
  assign ow_core_rst  = coreRst_q;
  assign ow_done      = done_q;
  assign ow_err       = err_q;
  assign ow_err_code  = errCode_q;

endmodule

// File: tb/tb_diad_boot.sv
// Directed bench for diad_boot: framed loads, each error path, empty and
// gapped frames, and a reset in the middle of a load.
module tb_diad_boot;
  import diad_boot_pkg::*;

  localparam int DATA_W = 24;
  localparam int ADDR_W = 24;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rstN;
  logic [7:0]        rxData;
  logic              rxValid;
  logic              rxReady;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic              coreRst;
  logic              done;
  logic              err;
  logic [1:0]        errCode;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] wrAddr[$];
  logic [DATA_W-1:0] wrData[$];
  logic [7:0]        frameQ[$];
  logic [7:0]        payloadQ[$];

  diad_boot #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .BASE   (0),
    .MAGIC  (8'hD1)
  ) dut (
    .iw_clk       (clk),
    .iw_rst_n     (rstN),
    .iw_rx_data   (rxData),
    .iw_rx_valid  (rxValid),
    .ow_rx_ready  (rxReady),
    .ow_mem_we    (memWe),
    .ow_mem_addr  (memAddr),
    .ow_mem_wdata (memWdata),
    .ow_core_rst  (coreRst),
    .ow_done      (done),
    .ow_err       (err),
    .ow_err_code  (errCode)
  );

  always #5 clk = ~clk;

  // Every cycle with the write strobe high is logged as one write.
  always @(negedge clk) begin
    if (memWe === 1'b1) begin
      wrAddr.push_back(memAddr);
      wrData.push_back(memWdata);
    end
  end

  task automatic applyReset();
    @(negedge clk);
    rstN    = 1'b0;
    rxValid = 1'b0;
    rxData  = 8'h00;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    wrAddr.delete();
    wrData.delete();
  endtask

  task automatic sendByte(input logic [7:0] b);
    int waitCnt = 0;
    while (rxReady !== 1'b1 && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    checks++;
    if (rxReady !== 1'b1) begin
      $display("[TB] FAIL send_ready: ready=%b required 1 for byte %h", rxReady, b);
      errors++;
    end else begin
      rxData  = b;
      rxValid = 1'b1;
      @(negedge clk);
      rxValid = 1'b0;
      rxData  = 8'h00;
    end
  endtask

  task automatic makeFrame(input logic [15:0] len, input logic [7:0] csum);
    logic [7:0] hdr [OFF_PAYLOAD];
    hdr[OFF_MAGIC]  = 8'hD1;
    hdr[OFF_LEN_LO] = len[7:0];
    hdr[OFF_LEN_HI] = len[15:8];
    frameQ.delete();
    for (int i = 0; i < OFF_PAYLOAD; i++) frameQ.push_back(hdr[i]);
    foreach (payloadQ[i]) frameQ.push_back(payloadQ[i]);
    frameQ.push_back(csum);
  endtask

  task automatic applyStimulus(input bit gapped);
    foreach (frameQ[i]) begin
      if (gapped && i > 0) repeat ($urandom_range(0, 3)) @(negedge clk);
      sendByte(frameQ[i]);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstN    = 1'b0;
    rxValid = 1'b0;
    rxData  = 8'h00;
    repeat (2) @(negedge clk);
    checks++; if (rxReady !== 1'b0) begin $display("[TB] FAIL reset_ready: got %b required 0", rxReady); errors++; end
    checks++; if (memWe !== 1'b0) begin $display("[TB] FAIL reset_we: got %b required 0", memWe); errors++; end
    checks++; if (memAddr !== '0) begin $display("[TB] FAIL reset_addr: got %h required 0", memAddr); errors++; end
    checks++; if (memWdata !== '0) begin $display("[TB] FAIL reset_wdata: got %h required 0", memWdata); errors++; end
    checks++; if (coreRst !== 1'b1) begin $display("[TB] FAIL reset_core_rst: got %b required 1", coreRst); errors++; end
    checks++; if (done !== 1'b0) begin $display("[TB] FAIL reset_done: got %b required 0", done); errors++; end
    checks++; if (err !== 1'b0) begin $display("[TB] FAIL reset_err: got %b required 0", err); errors++; end
    checks++; if (errCode !== 2'd0) begin $display("[TB] FAIL reset_code: got %0d required 0", errCode); errors++; end
    rstN = 1'b1;
    @(negedge clk);
    checks++; if (rxReady !== 1'b1) begin $display("[TB] FAIL release_ready: got %b required 1", rxReady); errors++; end
    checks++; if (coreRst !== 1'b1) begin $display("[TB] FAIL release_core_rst: got %b required 1", coreRst); errors++; end
  endtask

  task automatic test_nominal();
    logic [DATA_W-1:0] expData [2] = '{24'h332211, 24'h665544};
    applyReset();
    payloadQ = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    makeFrame(16'd2, 8'h65);
    for (int i = 0; i < frameQ.size() - 1; i++) sendByte(frameQ[i]);
    checks++;
    if (memWe !== 1'b1 || memAddr !== 24'd1 || memWdata !== 24'h665544) begin
      $display("[TB] FAIL nominal_last_write: we=%b addr=%h data=%h required we=1 addr=000001 data=665544", memWe, memAddr, memWdata);
      errors++;
    end
    checks++; if (coreRst !== 1'b1 || done !== 1'b0) begin $display("[TB] FAIL nominal_pre_csum: core_rst=%b done=%b required 1/0", coreRst, done); errors++; end
    sendByte(frameQ[frameQ.size() - 1]);
    checks++; if (coreRst !== 1'b0) begin $display("[TB] FAIL nominal_core_rst: got %b required 0", coreRst); errors++; end
    checks++; if (done !== 1'b1 || err !== 1'b0) begin $display("[TB] FAIL nominal_done: done=%b err=%b required 1/0", done, err); errors++; end
    checks++; if (rxReady !== 1'b0) begin $display("[TB] FAIL nominal_ready: got %b required 0", rxReady); errors++; end
    repeat (2) @(negedge clk);
    checks++; if (wrData.size() != 2) begin $display("[TB] FAIL nominal_count: got %0d writes required 2", wrData.size()); errors++; end
    for (int i = 0; i < 2 && i < wrData.size(); i++) begin
      checks++;
      if (wrAddr[i] !== ADDR_W'(i) || wrData[i] !== expData[i]) begin
        $display("[TB] FAIL nominal_write%0d: addr=%h data=%h required addr=%h data=%h", i, wrAddr[i], wrData[i], ADDR_W'(i), expData[i]);
        errors++;
      end
    end
  endtask

  task automatic test_bad_magic();
    applyReset();
    sendByte(8'hAA);
    checks++; if (err !== 1'b1 || errCode !== 2'd1) begin $display("[TB] FAIL magic_err: err=%b code=%0d required 1/1", err, errCode); errors++; end
    checks++; if (rxReady !== 1'b0) begin $display("[TB] FAIL magic_ready: got %b required 0", rxReady); errors++; end
    checks++; if (coreRst !== 1'b1 || done !== 1'b0) begin $display("[TB] FAIL magic_core: core_rst=%b done=%b required 1/0", coreRst, done); errors++; end
    repeat (3) @(negedge clk);
    checks++; if (wrData.size() != 0) begin $display("[TB] FAIL magic_writes: got %0d required 0", wrData.size()); errors++; end
  endtask

  task automatic test_len_too_large();
    applyReset();
    payloadQ.delete();
    makeFrame(16'd5, 8'h00);
    for (int i = 0; i < OFF_PAYLOAD; i++) sendByte(frameQ[i]);
    checks++; if (err !== 1'b1 || errCode !== 2'd2) begin $display("[TB] FAIL len_err: err=%b code=%0d required 1/2", err, errCode); errors++; end
    checks++; if (rxReady !== 1'b0 || coreRst !== 1'b1) begin $display("[TB] FAIL len_ready: ready=%b core_rst=%b required 0/1", rxReady, coreRst); errors++; end
    repeat (3) @(negedge clk);
    checks++; if (wrData.size() != 0) begin $display("[TB] FAIL len_writes: got %0d required 0", wrData.size()); errors++; end
  endtask

  task automatic test_len_boundary();
    logic [DATA_W-1:0] expData [4] = '{24'h030201, 24'h060504, 24'h090807, 24'h0C0B0A};
    applyReset();
    payloadQ = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
    makeFrame(16'd4, 8'h4E);
    applyStimulus(1'b0);
    checks++; if (done !== 1'b1 || err !== 1'b0 || coreRst !== 1'b0) begin $display("[TB] FAIL boundary_done: done=%b err=%b core_rst=%b required 1/0/0", done, err, coreRst); errors++; end
    repeat (2) @(negedge clk);
    checks++; if (wrData.size() != 4) begin $display("[TB] FAIL boundary_count: got %0d writes required 4", wrData.size()); errors++; end
    for (int i = 0; i < 4 && i < wrData.size(); i++) begin
      checks++;
      if (wrAddr[i] !== ADDR_W'(i) || wrData[i] !== expData[i]) begin
        $display("[TB] FAIL boundary_write%0d: addr=%h data=%h required addr=%h data=%h", i, wrAddr[i], wrData[i], ADDR_W'(i), expData[i]);
        errors++;
      end
    end
  endtask

  task automatic test_csum_mismatch();
    logic [DATA_W-1:0] expData [2] = '{24'h332211, 24'h665544};
    applyReset();
    payloadQ = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    makeFrame(16'd2, 8'h66);
    applyStimulus(1'b0);
    checks++; if (err !== 1'b1 || errCode !== 2'd3) begin $display("[TB] FAIL csum_err: err=%b code=%0d required 1/3", err, errCode); errors++; end
    checks++; if (coreRst !== 1'b1 || done !== 1'b0) begin $display("[TB] FAIL csum_core: core_rst=%b done=%b required 1/0", coreRst, done); errors++; end
    repeat (2) @(negedge clk);
    checks++; if (wrData.size() != 2) begin $display("[TB] FAIL csum_count: got %0d writes required 2", wrData.size()); errors++; end
    for (int i = 0; i < 2 && i < wrData.size(); i++) begin
      checks++;
      if (wrAddr[i] !== ADDR_W'(i) || wrData[i] !== expData[i]) begin
        $display("[TB] FAIL csum_write%0d: addr=%h data=%h required addr=%h data=%h", i, wrAddr[i], wrData[i], ADDR_W'(i), expData[i]);
        errors++;
      end
    end
  endtask

  task automatic test_empty();
    applyReset();
    payloadQ.delete();
    makeFrame(16'd0, 8'h00);
    applyStimulus(1'b0);
    checks++; if (done !== 1'b1 || coreRst !== 1'b0 || err !== 1'b0) begin $display("[TB] FAIL empty_done: done=%b core_rst=%b err=%b required 1/0/0", done, coreRst, err); errors++; end
    repeat (2) @(negedge clk);
    checks++; if (wrData.size() != 0) begin $display("[TB] FAIL empty_writes: got %0d required 0", wrData.size()); errors++; end
  endtask

  task automatic test_gapped();
    logic [DATA_W-1:0] expData [2] = '{24'h332211, 24'h665544};
    applyReset();
    payloadQ = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    makeFrame(16'd2, 8'h65);
    applyStimulus(1'b1);
    checks++; if (done !== 1'b1 || err !== 1'b0 || coreRst !== 1'b0) begin $display("[TB] FAIL gapped_done: done=%b err=%b core_rst=%b required 1/0/0", done, err, coreRst); errors++; end
    repeat (2) @(negedge clk);
    checks++; if (wrData.size() != 2) begin $display("[TB] FAIL gapped_count: got %0d writes required 2", wrData.size()); errors++; end
    for (int i = 0; i < 2 && i < wrData.size(); i++) begin
      checks++;
      if (wrAddr[i] !== ADDR_W'(i) || wrData[i] !== expData[i]) begin
        $display("[TB] FAIL gapped_write%0d: addr=%h data=%h required addr=%h data=%h", i, wrAddr[i], wrData[i], ADDR_W'(i), expData[i]);
        errors++;
      end
    end
  endtask

  task automatic test_reset_midload();
    logic [DATA_W-1:0] expData [2] = '{24'h332211, 24'h665544};
    applyReset();
    payloadQ = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    makeFrame(16'd2, 8'h65);
    for (int i = 0; i < OFF_PAYLOAD + 4; i++) sendByte(frameQ[i]);
    rstN = 1'b0;
    @(negedge clk);
    checks++; if (rxReady !== 1'b0 || memWe !== 1'b0 || coreRst !== 1'b1) begin $display("[TB] FAIL midreset_state: ready=%b we=%b core_rst=%b required 0/0/1", rxReady, memWe, coreRst); errors++; end
    rstN = 1'b1;
    @(negedge clk);
    wrAddr.delete();
    wrData.delete();
    applyStimulus(1'b0);
    checks++; if (done !== 1'b1 || err !== 1'b0) begin $display("[TB] FAIL midreset_done: done=%b err=%b required 1/0", done, err); errors++; end
    repeat (2) @(negedge clk);
    checks++; if (wrData.size() != 2) begin $display("[TB] FAIL midreset_count: got %0d writes required 2", wrData.size()); errors++; end
    for (int i = 0; i < 2 && i < wrData.size(); i++) begin
      checks++;
      if (wrAddr[i] !== ADDR_W'(i) || wrData[i] !== expData[i]) begin
        $display("[TB] FAIL midreset_write%0d: addr=%h data=%h required addr=%h data=%h", i, wrAddr[i], wrData[i], ADDR_W'(i), expData[i]);
        errors++;
      end
    end
  endtask

  initial begin
    rstN    = 1'b0;
    rxValid = 1'b0;
    rxData  = 8'h00;
    test_reset();
    test_nominal();
    test_bad_magic();
    test_len_too_large();
    test_len_boundary();
    test_csum_mismatch();
    test_empty();
    test_gapped();
    test_reset_midload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
